mat4_mult_seq: RTL and testbench



---
 rtl/mat4_pkg.sv | 19 +
 rtl/mat4_dot4.sv | 28 ++
 rtl/mat4_mult_seq.sv | 112 +++++++++++
 tb/tb_mat4_mult_seq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat4_pkg.sv
// Shared definitions for the sequential 4x4 matrix multiplier: matrix geometry,
// controller states and the packed-element offset helper.
package mat4_pkg;

    localparam int MAT_N     = 4;
    localparam int MAT_ELEMS = MAT_N * MAT_N;

    typedef enum logic [1:0] {
        IDLE,
        COMP,
        DONE
    } state_t;

    // Element 0 sits in the MSBs, so offsets count down from the top of the vector.
    function automatic int el_lo(input int idx, input int w);
        return (MAT_ELEMS - 1 - idx) * w;
    endfunction

endpackage

// File: rtl/mat4_dot4.sv
// Combinational 4-term unsigned dot product; the single arithmetic unit shared
// across all 16 result elements.
module mat4_dot4 #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2 * DATA_W + 2
) (
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    input  logic [DATA_W-1:0] a3,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b2,
    input  logic [DATA_W-1:0] b3,
    output logic [ACC_W-1:0]  sum
);

    logic [2*DATA_W-1:0] p0, p1, p2, p3;

    assign p0 = a0 * b0;
    assign p1 = a1 * b1;
    assign p2 = a2 * b2;
    assign p3 = a3 * b3;

    // Two guard bits absorb the carries of four full-width products.
    assign sum = ACC_W'(p0) + ACC_W'(p1) + ACC_W'(p2) + ACC_W'(p3);

endmodule

// File: rtl/mat4_mult_seq.sv
// Sequential 4x4 unsigned matrix multiplier: C = A x B, one result element per
// cycle through a single shared dot-product unit, valid/ready on both sides.
module mat4_mult_seq
    import mat4_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2 * DATA_W + 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAT_ELEMS*DATA_W-1:0]   a_mat,
    input  logic [MAT_ELEMS*DATA_W-1:0]   b_mat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAT_ELEMS*ACC_W-1:0]    c_mat
);

    state_t                        state, state_next;
    logic [3:0]                    cnt;
    logic [1:0]                    row, col;
    logic                          accept;
    logic [MAT_ELEMS*DATA_W-1:0]   a_reg, b_reg;
    logic [MAT_ELEMS*ACC_W-1:0]    c_reg;
    logic [DATA_W-1:0]             a_el [MAT_N][MAT_N];
    logic [DATA_W-1:0]             b_el [MAT_N][MAT_N];
    logic [ACC_W-1:0]              dot_sum;

    // Controller: next state and handshake outputs.
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = COMP;
            end
            COMP: begin
                if (cnt == 4'd15) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Unpack the registered operands into row/column addressable elements.
    always_comb begin
        for (int r = 0; r < MAT_N; r++) begin
            for (int c = 0; c < MAT_N; c++) begin
                a_el[r][c] = a_reg[el_lo(r * MAT_N + c, DATA_W) +: DATA_W];
                b_el[r][c] = b_reg[el_lo(r * MAT_N + c, DATA_W) +: DATA_W];
            end
        end
    end

    assign row = cnt[3:2];
    assign col = cnt[1:0];

    mat4_dot4 #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_dot (
        .a0  (a_el[row][0]),
        .a1  (a_el[row][1]),
        .a2  (a_el[row][2]),
        .a3  (a_el[row][3]),
        .b0  (b_el[0][col]),
        .b1  (b_el[1][col]),
        .b2  (b_el[2][col]),
        .b3  (b_el[3][col]),
        .sum (dot_sum)
    );

    // Operand capture, element counter and result write-back.
    // NOTE: operand and result registers are reset so an aborted job leaves no stale data visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= '0;
        end else begin
            if (accept) begin
                a_reg <= a_mat;
                b_reg <= b_mat;
                cnt   <= '0;
            end else if (state == COMP) begin
                for (int e = 0; e < MAT_ELEMS; e++) begin
                    if (cnt == 4'(e)) c_reg[el_lo(e, ACC_W) +: ACC_W] <= dot_sum;
                end
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign c_mat = c_reg;

endmodule

// File: tb/tb_mat4_mult_seq.sv
// Self-checking bench for mat4_mult_seq: directed and random matrices compared
// against a plain-arithmetic matrix product model.
module tb_mat4_mult_seq;

    localparam int DW = 8;
    localparam int AW = 2 * DW + 2;
    localparam int MW = 16 * DW;
    localparam int CW = 16 * AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] a_mat;
    logic [MW-1:0] b_mat;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] c_mat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mat4_mult_seq #(
        .DATA_W (DW),
        .ACC_W  (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_mat     (a_mat),
        .b_mat     (b_mat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_mat     (c_mat)
    );

    // ---------------- reference model ----------------
    function automatic int unsigned get_el(input logic [MW-1:0] m, input int r, input int c);
        return {24'd0, m[(15 - (r * 4 + c)) * DW +: DW]};
    endfunction

    function automatic logic [CW-1:0] ref_mult(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [CW-1:0] res;
        int unsigned   s;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += get_el(a, r, k) * get_el(b, k, c);
                res[(15 - (r * 4 + c)) * AW +: AW] = s[AW-1:0];
            end
        end
        return res;
    endfunction

    function automatic logic [AW-1:0] c_el(input logic [CW-1:0] m, input int i);
        return m[(15 - i) * AW +: AW];
    endfunction

    function automatic logic [MW-1:0] seq_mat(input int start);
        logic [MW-1:0] m;
        for (int i = 0; i < 16; i++) m[(15 - i) * DW +: DW] = DW'(start + i);
        return m;
    endfunction

    function automatic logic [MW-1:0] ident_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < 16; i++) m[(15 - i) * DW +: DW] = (i % 5 == 0) ? DW'(1) : DW'(0);
        return m;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < 16; i++) m[(15 - i) * DW +: DW] = DW'($urandom);
        return m;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for in_ready, and let one edge accept them.
    task automatic accept(input logic [MW-1:0] a, input logic [MW-1:0] b, input bit keep);
        int t;
        t = 0;
        a_mat    = a;
        b_mat    = b;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            step();
            t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b, expected 1", in_ready);
        end
        step();
        if (!keep) in_valid = 1'b0;
    endtask

    // Called just after the accepting edge; checks latency, busy and all 16 elements.
    task automatic wait_result(input logic [MW-1:0] a, input logic [MW-1:0] b, input string name);
        int            cyc;
        int            busy_err;
        logic [CW-1:0] exp;
        cyc      = 0;
        busy_err = 0;
        exp      = ref_mult(a, b);
        while (out_valid !== 1'b1 && cyc < 100) begin
            if (in_ready !== 1'b0) busy_err++;
            step();
            cyc++;
        end
        checks++;
        if (cyc != 16) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected 16", name, cyc);
        end
        checks++;
        if (busy_err != 0) begin
            errors++;
            $display("FAIL %s in_ready_busy: in_ready high %0d cycles during compute, expected 0", name, busy_err);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (c_el(c_mat, i) !== c_el(exp, i)) begin
                errors++;
                $display("FAIL %s elem %0d: got %0d, expected %0d", name, i, c_el(c_mat, i), c_el(exp, i));
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_mat     = '0;
        b_mat     = '0;
        repeat (3) step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || c_mat !== '0) begin
            errors++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b c_mat=%h, expected 1 0 0", in_ready, out_valid, c_mat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_sequential();
        logic [MW-1:0] a, b;
        a = seq_mat(1);
        b = seq_mat(17);
        accept(a, b, 1'b0);
        wait_result(a, b, "seq");
        checks++;
        if (c_el(c_mat, 0) !== 18'd250 || c_el(c_mat, 1) !== 18'd260 || c_el(c_mat, 15) !== 18'd1528) begin
            errors++;
            $display("FAIL seq_known: c00=%0d c01=%0d c33=%0d, expected 250 260 1528",
                     c_el(c_mat, 0), c_el(c_mat, 1), c_el(c_mat, 15));
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL seq_handshake: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_identity_and_max();
        logic [MW-1:0] b, m;
        b = seq_mat(1);
        accept(ident_mat(), b, 1'b0);
        wait_result(ident_mat(), b, "identity");
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (c_el(c_mat, i) !== AW'(i + 1)) begin
                errors++;
                $display("FAIL identity_b elem %0d: got %0d, expected %0d", i, c_el(c_mat, i), i + 1);
            end
        end
        step();
        m = '1;
        accept(m, m, 1'b0);
        wait_result(m, m, "max");
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (c_el(c_mat, i) !== 18'd260100) begin
                errors++;
                $display("FAIL max_value elem %0d: got %0d, expected 260100", i, c_el(c_mat, i));
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [MW-1:0] a, b;
        logic [CW-1:0] exp;
        int            bad;
        a         = rand_mat();
        b         = rand_mat();
        exp       = ref_mult(a, b);
        out_ready = 1'b0;
        accept(a, b, 1'b0);
        wait_result(a, b, "bp");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || c_mat !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles, expected 0", bad);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
        repeat (3) step();
        checks++;
        if (c_mat !== exp) begin
            errors++;
            $display("FAIL idle_hold: c_mat=%h, expected %h", c_mat, exp);
        end
    endtask

    task automatic test_in_valid_during_comp();
        logic [MW-1:0] a1, b1, a2, b2;
        a1 = rand_mat();
        b1 = rand_mat();
        a2 = rand_mat();
        b2 = rand_mat();
        accept(a1, b1, 1'b1);
        a_mat = a2;
        b_mat = b2;
        wait_result(a1, b1, "first_of_two");
        accept(a2, b2, 1'b0);
        wait_result(a2, b2, "second_of_two");
        step();
    endtask

    task automatic test_reset_mid_comp();
        logic [MW-1:0] a, b;
        int            bad;
        a = rand_mat();
        b = rand_mat();
        accept(a, b, 1'b0);
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || c_mat !== '0) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b c_mat=%h, expected 0 1 0", out_valid, in_ready, c_mat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad   = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_reset_no_valid: out_valid high %0d cycles, expected 0", bad);
        end
        a = rand_mat();
        b = rand_mat();
        accept(a, b, 1'b0);
        wait_result(a, b, "after_reset");
        step();
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] a [4];
        logic [MW-1:0] b [4];
        for (int m = 0; m < 4; m++) begin
            a[m] = rand_mat();
            b[m] = rand_mat();
        end
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            accept(a[m], b[m], m < 3);
            wait_result(a[m], b[m], $sformatf("b2b%0d", m));
            step();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b%0d spacing: in_ready=%b out_valid=%b 17 cycles after accept, expected 1 0",
                         m, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_identity_and_max();
        test_backpressure();
        test_in_valid_during_comp();
        test_reset_mid_comp();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
